deinterleaver_byte_out: RTL and testbench
=========================================

DEINTERLEAVER_BYTE_OUT -- requirements
Module: deinterleaver_byte_out

Interface
REQ-001 Parameter KMAX, default 6144, largest supported block size in bits.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 k_size_6144  input  1  block size select: 0 = 1056 bits, 1 = 6144 bits; sampled only at first accepted bit of a block.
REQ-005 bit_in  input  1  bit-serial interleaved stream, cpii order (bit i = c[pi(i)]).
REQ-006 valid_in  input  1  bit_in valid this cycle.
REQ-007 ready_in  output  1  module accepts a bit this cycle; a bit is accepted iff valid_in && ready_in.
REQ-008 databyte_out  output  8  byte-wise output in original c order.
REQ-009 byte_valid  output  1  databyte_out valid.
REQ-010 byte_ready  input  1  downstream accepts; a byte transfers iff byte_valid && byte_ready.
REQ-011 block_done  output  1  one-cycle pulse on transfer of the final byte of a block.

Function
REQ-012 State machine SHALL have states IDLE, FILL, DRAIN.
REQ-013 IDLE: ready_in=1, byte_valid=0; the first accepted bit latches K (1056 or 6144), is written at address pi(0)=0, and moves to FILL (or stays if K-1 reached, not possible for valid K).
REQ-014 FILL: ready_in=1; accepted bit i SHALL be written to buffer[pi(i)]; cycles without valid_in SHALL hold i and the address state unchanged.
REQ-015 Address SHALL follow QPP pi(i) = (f1*i + f2*i^2) mod K with (f1,f2) = (17,66) for K=1056 and (263,480) for K=6144.
REQ-016 pi SHALL be computed recursively, no multipliers: pi(0)=0, g(0)=(f1+f2) mod K; pi(i+1)=(pi(i)+g(i)) mod K; g(i+1)=(g(i)+2*f2) mod K.
REQ-017 Each mod-K add SHALL be computed as 14-bit sum of two operands < K, minus K if sum >= K; pi, g, i SHALL be 13 bits.
REQ-018 On acceptance of bit i=K-1, state SHALL move to DRAIN; ready_in SHALL be 0 in the following cycle and throughout DRAIN.
REQ-019 DRAIN: byte_valid=1 from the first DRAIN cycle; byte j (0..K/8-1) SHALL carry databyte_out[b] = c[8j+b], b=0..7.
REQ-020 While byte_valid && !byte_ready, databyte_out SHALL hold stable; j SHALL advance only on transfer.
REQ-021 On transfer of byte K/8-1 (131 or 767): block_done=1 that cycle, state SHALL return to IDLE next cycle, byte_valid=0.
REQ-022 valid_in while ready_in=0 SHALL be ignored (no write, no counter change).
REQ-023 k_size_6144 changes during FILL or DRAIN SHALL have no effect on the current block.
REQ-024 Latency: first byte_valid SHALL assert exactly one cycle after acceptance of bit K-1.
REQ-025 Throughput: one bit/cycle in, one byte/cycle out; no overlap of FILL and DRAIN.

Reset
REQ-026 rst=0 at a clock edge SHALL force state IDLE, i=0, pi=0, g=0, j=0, K latch=1056, ready_in=1 after release, byte_valid=0, block_done=0, databyte_out=8'h00.
REQ-027 Reset mid-FILL or mid-DRAIN SHALL abandon the block; buffer contents SHALL NOT be reset and are don't-care until overwritten.
REQ-028 During rst=0, ready_in SHALL be 0.

Structure
REQ-029 Shared package SHALL hold K values (1056, 6144), byte counts (132, 768), f1/f2 per K, and the IDLE/FILL/DRAIN state encoding.
REQ-030 Sub-module qpp_addr_gen SHALL contain i, pi, g registers and the mod-K adders, with inputs clock, rst, k_size, start, step and output addr[12:0].
REQ-031 Buffer SHALL be a KMAX-bit single-write-port storage with byte-wide read at index j.

Verification
REQ-032 K=1056, bit_in=1 only at i=1, all others 0, byte_ready=1 -> 132 bytes, byte 10 = 8'h08 (c[83]), all others 8'h00, block_done with byte 131.
REQ-033 K=6144, bit_in=1 only at i=2 -> 768 bytes, byte 305 = 8'h40 (c[2446]), all others 8'h00; byte_valid asserts 1 cycle after bit 6143.
REQ-034 K=1056, random c interleaved by a QPP reference model, valid_in randomly gapped -> 132 output bytes equal c exactly.
REQ-035 DRAIN with byte_ready toggled randomly -> databyte_out stable while stalled, no byte lost or duplicated, ready_in=0 throughout.
REQ-036 rst=0 after 500 bits of a 6144 block -> next cycle IDLE, byte_valid=0; fresh 1056 block then deinterleaves correctly.
REQ-037 k_size_6144 flipped 0->1 at bit 100 of a 1056 block -> exactly 132 bytes output, correct data.

Source files
------------

// File: rtl/deinterleaver_byte_out_pkg.sv
// ---------------------------------------------------------------------------
// deinterleaver_byte_out_pkg
//   Shared constants and helpers for the QPP bit deinterleaver:
//   - supported block sizes K (1056 / 6144) and their byte counts
//   - QPP coefficients (f1, f2) per block size
//   - FSM state encoding
//   - a mod-K adder for operands already reduced below K
// ---------------------------------------------------------------------------
package deinterleaver_byte_out_pkg;

    localparam int unsigned K_SMALL    = 1056;
    localparam int unsigned K_LARGE    = 6144;
    localparam int unsigned NB_SMALL   = K_SMALL / 8;   // 132
    localparam int unsigned NB_LARGE   = K_LARGE / 8;   // 768

    localparam int unsigned F1_SMALL   = 17;
    localparam int unsigned F2_SMALL   = 66;
    localparam int unsigned F1_LARGE   = 263;
    localparam int unsigned F2_LARGE   = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Block size in bits for the size select (1 = 6144).
    function automatic logic [12:0] k_of(input logic big);
        return big ? 13'(K_LARGE) : 13'(K_SMALL);
    endfunction

    // g(0) = (f1 + f2) mod K; both sums are already below K.
    function automatic logic [12:0] g_init(input logic big);
        return big ? 13'(F1_LARGE + F2_LARGE) : 13'(F1_SMALL + F2_SMALL);
    endfunction

    // Constant increment of g: 2*f2, already below K.
    function automatic logic [12:0] g_step(input logic big);
        return big ? 13'(2 * F2_LARGE) : 13'(2 * F2_SMALL);
    endfunction

    // Index of the final output byte of a block.
    function automatic logic [9:0] last_byte(input logic big);
        return big ? 10'(NB_LARGE - 1) : 10'(NB_SMALL - 1);
    endfunction

    // (a + b) mod k for a, b < k: one 14-bit add and a conditional subtract.
    function automatic logic [12:0] mod_add(input logic [12:0] a,
                                            input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, k}) ? 13'(s - {1'b0, k}) : s[12:0];
    endfunction

endpackage

// File: rtl/deinterleaver_byte_out_qpp_addr_gen.sv
// ---------------------------------------------------------------------------
// qpp_addr_gen
//   Multiplier-free QPP address generator: pi(i) = (f1*i + f2*i^2) mod K,
//   produced by second-order recursion on (pi, g).
//   Ports:
//     clock   rising-edge clock
//     rst     synchronous active-low reset
//     k_size  block size select for the current step (1 = 6144)
//     start   advance from bit 0 (g is seeded with g(0) on this step)
//     step    advance from bit i > 0
//     addr    pi(i) for the current bit i
//     last    current bit is i = K-1
// ---------------------------------------------------------------------------
module qpp_addr_gen
    import deinterleaver_byte_out_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        k_size,
    input  logic        start,
    input  logic        step,
    output logic [12:0] addr,
    output logic        last
);

    logic [12:0] i_q, i_d;
    logic [12:0] pi_q, pi_d;
    logic [12:0] g_q, g_d;
    logic [12:0] k_val;
    logic [12:0] g_use;

    assign addr = pi_q;

    always_comb begin
        i_d   = i_q;
        pi_d  = pi_q;
        g_d   = g_q;
        k_val = k_of(k_size);
        // g is held at 0 between blocks; the first step uses g(0) directly.
        g_use = start ? g_init(k_size) : g_q;
        last  = (i_q == k_val - 13'd1);
        if (start || step) begin
            if (last) begin
                // Block complete: park at i=0 so the next block starts at pi(0)=0.
                i_d  = '0;
                pi_d = '0;
                g_d  = '0;
            end else begin
                i_d  = i_q + 13'd1;
                pi_d = mod_add(pi_q, g_use, k_val);
                g_d  = mod_add(g_use, g_step(k_size), k_val);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            i_q  <= '0;
            pi_q <= '0;
            g_q  <= '0;
        end else begin
            i_q  <= i_d;
            pi_q <= pi_d;
            g_q  <= g_d;
        end
    end

endmodule

// File: rtl/deinterleaver_byte_out.sv
// ---------------------------------------------------------------------------
// deinterleaver_byte_out
//   Accepts a QPP-interleaved bit stream (bit i = c[pi(i)]) one bit per
//   cycle, writes each bit to buffer[pi(i)], then drains the buffer as bytes
//   in natural c order (databyte_out[b] = c[8j+b]). FILL and DRAIN never
//   overlap.
//   Ports:
//     clock, rst      rising-edge clock, synchronous active-low reset
//     k_size_6144     block size select, sampled at the first bit of a block
//     bit_in/valid_in/ready_in            bit-serial input handshake
//     databyte_out/byte_valid/byte_ready  byte output handshake
//     block_done      pulse on transfer of the last byte of a block
// ---------------------------------------------------------------------------
module deinterleaver_byte_out
    import deinterleaver_byte_out_pkg::*;
#(
    parameter int KMAX = 6144
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       k_size_6144,
    input  logic       bit_in,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [7:0] databyte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       block_done
);

    state_t            state_q, state_d;
    logic              k_q, k_d;          // latched size select, 0 = 1056
    logic [9:0]        j_q, j_d;          // output byte index
    logic [7:0]        byte_q, byte_d;
    logic [KMAX-1:0]   buf_q, buf_d;

    logic              accept;
    logic              xfer;
    logic              gen_k;
    logic              start;
    logic              step;
    logic              last_bit;
    logic [12:0]       addr;
    logic [12:0]       rd_base;

    // Input side is closed while draining and while reset is held.
    assign ready_in     = rst && (state_q != ST_DRAIN);
    assign byte_valid   = (state_q == ST_DRAIN);
    assign databyte_out = byte_q;
    assign accept       = valid_in && ready_in;
    assign xfer         = byte_valid && byte_ready;
    assign block_done   = xfer && (j_q == last_byte(k_q));

    // The size input is only looked at for the first bit; after that the latch rules.
    assign gen_k = (state_q == ST_IDLE) ? k_size_6144 : k_q;
    assign start = accept && (state_q == ST_IDLE);
    assign step  = accept && (state_q == ST_FILL);

    qpp_addr_gen u_addr_gen (
        .clock  (clock),
        .rst    (rst),
        .k_size (gen_k),
        .start  (start),
        .step   (step),
        .addr   (addr),
        .last   (last_bit)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        byte_d  = byte_q;
        buf_d   = buf_q;
        rd_base = '0;

        if (accept) buf_d[addr] = bit_in;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    k_d     = k_size_6144;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept && last_bit) begin
                    state_d = ST_DRAIN;
                    j_d     = '0;
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    if (block_done) state_d = ST_IDLE;
                    else            j_d     = j_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output byte is registered; read from the next-state buffer so the
        // last bit written on entry to DRAIN is already visible in byte 0.
        rd_base = {j_d, 3'b000};
        if (state_d == ST_DRAIN) byte_d = buf_d[rd_base +: 8];
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= 1'b0;
            j_q     <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            byte_q  <= byte_d;
        end
    end

    // Buffer contents are don't-care after reset until overwritten.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_deinterleaver_byte_out.sv
// ---------------------------------------------------------------------------
// tb_deinterleaver_byte_out
//   Directed sequence with random data, gaps and back-pressure. The reference
//   is a plain array c[]; the stream fed in is c[pi(i)] with pi evaluated by
//   the closed-form QPP polynomial, and output bytes are compared to c.
// ---------------------------------------------------------------------------
module tb_deinterleaver_byte_out;

    logic       clock = 1'b0;
    logic       rst;
    logic       k_size_6144;
    logic       bit_in;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] databyte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       block_done;

    int total = 0;
    int bad   = 0;

    bit         c_ref [0:6143];
    logic [7:0] rx    [0:767];

    deinterleaver_byte_out #(.KMAX(6144)) dut (
        .clock        (clock),
        .rst          (rst),
        .k_size_6144  (k_size_6144),
        .bit_in       (bit_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .databyte_out (databyte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .block_done   (block_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Closed-form QPP permutation.
    function automatic int qpp(input int k, input int i);
        longint f1, f2, ii;
        f1 = (k == 1056) ? 17 : 263;
        f2 = (k == 1056) ? 66 : 480;
        ii = i;
        return int'((f1 * ii + f2 * ii * ii) % longint'(k));
    endfunction

    task automatic clear_c();
        for (int n = 0; n < 6144; n++) c_ref[n] = 1'b0;
    endtask

    task automatic random_c(input int k);
        clear_c();
        for (int n = 0; n < k; n++) c_ref[n] = 1'($urandom_range(1));
    endtask

    // Feed bits 0..stop_after-1 of the interleaved stream; flip_at >= 0 inverts
    // the size select from that bit onwards. Called at posedge+1.
    task automatic feed(input int k, input bit k_sel, input int gap_pct,
                        input int flip_at, input int stop_after);
        int i   = 0;
        int cyc = 0;
        bit acc;
        while (i < stop_after && cyc < 30000) begin
            valid_in    = ($urandom_range(99) >= gap_pct);
            bit_in      = valid_in ? c_ref[qpp(k, i)] : 1'($urandom_range(1));
            k_size_6144 = (flip_at >= 0 && i >= flip_at) ? ~k_sel : k_sel;
            @(negedge clock);
            if (cyc == 0) check("fill_ready_in", 32'(ready_in), 32'd1);
            acc = valid_in && ready_in;
            if (acc && i == k - 1) check("fill_bv_before_last", 32'(byte_valid), 32'd0);
            @(posedge clock);
            #1;
            cyc++;
            if (acc) i++;
        end
        valid_in = 1'b0;
        check("feed_count", i, stop_after);
        if (stop_after == k) begin
            // One cycle after acceptance of bit K-1.
            check("latency_bv", 32'(byte_valid), 32'd1);
            check("latency_rdy", 32'(ready_in), 32'd0);
        end
    endtask

    // Drain one block with random back-pressure. Called at posedge+1.
    task automatic drain(input int k, input int rdy_pct);
        int         nb  = k / 8;
        int         n   = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] e;
        while (n < nb && cyc < 20000) begin
            byte_ready = ($urandom_range(99) < rdy_pct);
            valid_in   = 1'($urandom_range(1));   // must be ignored
            bit_in     = 1'($urandom_range(1));
            @(negedge clock);
            check("drain_ready_in", 32'(ready_in), 32'd0);
            check("drain_bv", 32'(byte_valid), 32'd1);
            if (stalled) check("stall_hold", 32'(databyte_out), 32'(held));
            check("block_done", 32'(block_done), 32'(byte_ready && n == nb - 1));
            if (byte_valid && byte_ready) begin
                for (int b = 0; b < 8; b++) e[b] = c_ref[8 * n + b];
                rx[n] = databyte_out;
                check("byte_data", 32'(databyte_out), 32'(e));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = byte_valid;
                held    = databyte_out;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        byte_ready = 1'b0;
        valid_in   = 1'b0;
        check("drain_count", n, nb);
        check("after_bv", 32'(byte_valid), 32'd0);
        check("after_ready_in", 32'(ready_in), 32'd1);
    endtask

    initial begin
        rst         = 1'b0;
        k_size_6144 = 1'b0;
        bit_in      = 1'b0;
        valid_in    = 1'b1;
        byte_ready  = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_ready_in", 32'(ready_in), 32'd0);
        @(posedge clock);
        #1;
        check("rst_bv", 32'(byte_valid), 32'd0);
        check("rst_done", 32'(block_done), 32'd0);
        check("rst_data", 32'(databyte_out), 32'h00);
        valid_in = 1'b0;
        @(posedge clock);
        #1;
        rst = 1'b1;
        @(negedge clock);
        check("post_rst_ready_in", 32'(ready_in), 32'd1);
        @(posedge clock);
        #1;

        // Single 1 at i=1 of a 1056 block -> c[83], byte 10 = 8'h08
        clear_c();
        c_ref[qpp(1056, 1)] = 1'b1;
        feed(1056, 1'b0, 0, -1, 1056);
        drain(1056, 100);
        check("k1056_byte10", 32'(rx[10]), 32'h08);

        // Single 1 at i=2 of a 6144 block -> c[2446], byte 305 = 8'h40
        clear_c();
        c_ref[qpp(6144, 2)] = 1'b1;
        feed(6144, 1'b1, 0, -1, 6144);
        drain(6144, 100);
        check("k6144_byte305", 32'(rx[305]), 32'h40);

        // Random data, gapped input
        random_c(1056);
        feed(1056, 1'b0, 30, -1, 1056);
        drain(1056, 100);

        // Random data, random back-pressure
        random_c(1056);
        feed(1056, 1'b0, 0, -1, 1056);
        drain(1056, 50);

        // Reset mid-FILL of a 6144 block, then a fresh 1056 block
        random_c(6144);
        feed(6144, 1'b1, 10, -1, 500);
        rst = 1'b0;
        @(negedge clock);
        check("midrst_ready_in", 32'(ready_in), 32'd0);
        @(posedge clock);
        #1;
        check("midrst_bv", 32'(byte_valid), 32'd0);
        rst = 1'b1;
        @(negedge clock);
        check("midrst_release_ready_in", 32'(ready_in), 32'd1);
        check("midrst_release_bv", 32'(byte_valid), 32'd0);
        @(posedge clock);
        #1;
        random_c(1056);
        feed(1056, 1'b0, 20, -1, 1056);
        drain(1056, 70);

        // Size select flipped 0->1 at bit 100 of a 1056 block
        random_c(1056);
        feed(1056, 1'b0, 10, 100, 1056);
        k_size_6144 = 1'b0;
        drain(1056, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
